// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision accumulator.
//   fp32_t       : packed IEEE-754 single {sign, exp, frac}
//   facc_state_e : accumulator FSM states
//   EXP_BIAS, FP_ZERO, FP_MAX_MAG : format constants
package fp_pkg;
  localparam int          EXP_BIAS   = 127;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [30:0] FP_MAX_MAG = 31'h7F7F_FFFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_FIN,
    S_OUT
  } facc_state_e;

  // Zero regardless of sign; denormals are not part of the format.
  function automatic logic fp_is_zero(input fp32_t v);
    return (v.exp == 8'd0) && (v.frac == 23'd0);
  endfunction
endpackage

// File: rtl/fadd_align.sv
// Operand alignment for the accumulator adder (purely combinational).
//   a, b : the two addends
//   x    : addend with the larger (or equal) exponent
//   my   : hidden-bit mantissa of the other addend, shifted right by the
//          exponent difference, shifted-out bits truncated
//   swap : 1 when b was selected as x
module fadd_align
  import fp_pkg::*;
(
  input  fp32_t       a,
  input  fp32_t       b,
  output fp32_t       x,
  output logic [23:0] my,
  output logic        swap
);
  logic [7:0]  ye;
  logic [22:0] yf;
  logic [7:0]  d;

  always_comb begin
    swap = (b.exp > a.exp);
    x    = swap ? b : a;
    ye   = swap ? a.exp  : b.exp;
    yf   = swap ? a.frac : b.frac;
    d    = x.exp - ye;
    // Anything past 24 positions is gone entirely; clamp so the shifter
    // never has to reason about oversize shift amounts.
    my   = (d >= 8'd25) ? 24'd0 : ({1'b1, yf} >> d);
  end
endmodule

// File: rtl/facc.sv
// Sequential single-precision accumulator. Takes one operand per handshake,
// adds it to the running total over several cycles (align, add, one-bit-per-
// cycle normalise) and presents the sum once the operand flagged last has
// been absorbed.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : operand stream
//   out_valid/out_ready/out_data/out_count : result, held until accepted
module facc
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);
  facc_state_e state, state_n;

  fp32_t            acc, op;
  logic [CNT_W-1:0] count;
  logic             last_q;

  // aligned operands held between ALIGN and ADD
  logic        xs, ys;
  logic [7:0]  ex;
  logic [23:0] mx, my;

  // normalisation working registers (bit 23 is known zero while in NORM)
  logic [22:0] sreg;
  logic [7:0]  e_r;
  logic        sign_r;

  logic [31:0]      odata;
  logic [CNT_W-1:0] ocount;

  fp32_t       al_x;
  logic [23:0] al_my;
  logic        al_swap;

  fadd_align u_align (
    .a   (acc),
    .b   (op),
    .x   (al_x),
    .my  (al_my),
    .swap(al_swap)
  );

  logic op_zero, acc_zero;
  assign op_zero  = fp_is_zero(op);
  assign acc_zero = fp_is_zero(acc);

  // ADD-stage arithmetic on the registered aligned operands
  logic [24:0] sum;
  logic        ssign;
  logic [7:0]  e_inc;

  always_comb begin
    sum   = '0;
    ssign = xs;
    if (xs == ys) begin
      sum   = {1'b0, mx} + {1'b0, my};
      ssign = xs;
    end else if (mx >= my) begin
      sum   = {1'b0, mx - my};
      ssign = xs;
    end else begin
      sum   = {1'b0, my - mx};
      ssign = ys;
    end
    e_inc = ex + 8'd1;
  end

  // NORM-stage single-bit left shift
  logic [23:0] ns;
  logic [7:0]  ne;
  assign ns = {sreg, 1'b0};
  assign ne = e_r - 8'd1;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_OUT) && !rst;
  assign out_data  = odata;
  assign out_count = ocount;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_n = S_ALIGN;
      S_ALIGN: state_n = (op_zero || acc_zero) ? S_FIN : S_ADD;
      S_ADD:   state_n = (sum == 25'd0 || sum[24] || sum[23]) ? S_FIN : S_NORM;
      S_NORM:  if (ne == 8'd0 || ns[23]) state_n = S_FIN;
      S_FIN:   state_n = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= FP_ZERO;
      op     <= FP_ZERO;
      count  <= '0;
      last_q <= 1'b0;
      xs     <= 1'b0;
      ys     <= 1'b0;
      ex     <= '0;
      mx     <= '0;
      my     <= '0;
      sreg   <= '0;
      e_r    <= '0;
      sign_r <= 1'b0;
      odata  <= FP_ZERO;
      ocount <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          op     <= in_data;
          last_q <= in_last;
          if (count != '1) count <= count + CNT_W'(1);
        end
        S_ALIGN: begin
          if (op_zero) begin
            // zero term (either sign) leaves the total alone
          end else if (acc_zero) begin
            acc <= op;
          end else begin
            xs <= al_x.sign;
            ys <= al_swap ? acc.sign : op.sign;
            ex <= al_x.exp;
            mx <= {1'b1, al_x.frac};
            my <= al_my;
          end
        end
        S_ADD: begin
          if (sum == 25'd0) begin
            acc <= FP_ZERO;
          end else if (sum[24]) begin
            if (e_inc == 8'hFF) acc <= {ssign, FP_MAX_MAG};
            else                acc <= {ssign, e_inc, sum[23:1]};
          end else if (sum[23]) begin
            acc <= {ssign, ex, sum[22:0]};
          end else begin
            sreg   <= sum[22:0];
            e_r    <= ex;
            sign_r <= ssign;
          end
        end
        S_NORM: begin
          sreg <= ns[22:0];
          e_r  <= ne;
          // exponent underflow flushes to +0 rather than producing a denormal
          if (ne == 8'd0)  acc <= FP_ZERO;
          else if (ns[23]) acc <= {sign_r, ne, ns[22:0]};
        end
        S_FIN: if (last_q) begin
          odata  <= acc;
          ocount <= count;
        end
        S_OUT: if (out_ready) begin
          acc   <= FP_ZERO;
          count <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_facc.sv
module tb_facc;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0]   in_data, out_data;
  logic [CW-1:0] out_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  facc #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  // Reference: exact integer arithmetic on hidden-bit mantissas, truncating
  // alignment, then renormalise by leading-one search.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    int ex, ey, d;
    longint mx, my, s;
    logic sg;
    if (b[30:0] == 31'd0) return a;
    if (a[30:0] == 31'd0) return b;
    if (b[30:23] > a[30:23]) begin x = b; y = a; end
    else begin x = a; y = b; end
    ex = int'(x[30:23]); ey = int'(y[30:23]); d = ex - ey;
    mx = longint'({1'b1, x[22:0]});
    my = (d >= 25) ? 0 : (longint'({1'b1, y[22:0]}) >> d);
    if (x[31] == y[31]) begin s = mx + my; sg = x[31]; end
    else if (mx >= my) begin s = mx - my; sg = x[31]; end
    else begin s = my - mx; sg = y[31]; end
    if (s == 0) return 32'h0;
    if (s >= (64'd1 << 24)) begin
      s = s >> 1; ex++;
      if (ex >= 255) return {sg, 31'h7F7FFFFF};
    end else begin
      while (s < (64'd1 << 23)) begin s = s << 1; ex--; end
    end
    if (ex <= 0) return 32'h0;
    return {sg, 8'(ex), 23'(s)};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] acc);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return acc ^ 32'h8000_0000;
      3: if (acc[30:23] < 8'd2) return 32'h0;
         else return {~acc[31], acc[30:8], 8'($urandom_range(0, 255))};
      4: return {1'($urandom_range(0, 1)), 8'($urandom_range(250, 254)), 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
    endcase
  endfunction

  task automatic send_op(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Call right after the accepting edge of the last operand; cyc counts the
  // clock edges until out_valid is seen.
  task automatic get_out(output logic [31:0] d, output logic [CW-1:0] c, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL out_timeout: out_valid=%0b required 1", out_valid);
    end
    d = out_data; c = out_count;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_sum(input logic [31:0] ops[$], output logic [31:0] d,
                        output logic [CW-1:0] c, output int cyc);
    foreach (ops[i]) send_op(ops[i], i == ops.size() - 1);
    get_out(d, c, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_chk++; if (out_count !== '0) begin n_fail++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [CW-1:0] c; int cyc;
    do_sum('{32'h3F800000, 32'h40000000}, d, c, cyc);
    n_chk++; if (d !== 32'h40400000) begin n_fail++; $display("FAIL basic_data: got %h want 40400000", d); end
    n_chk++; if (c !== CW'(2)) begin n_fail++; $display("FAIL basic_count: got %0d want 2", c); end
    n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", cyc); end
  endtask

  task automatic test_cancel();
    logic [31:0] d; logic [CW-1:0] c; int cyc;
    do_sum('{32'h3F800000, 32'hBF800000}, d, c, cyc);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL cancel_data: got %h want 00000000", d); end
    do_sum('{32'h40000000}, d, c, cyc);
    n_chk++; if (d !== 32'h40000000) begin n_fail++; $display("FAIL cleared_data: got %h want 40000000", d); end
    n_chk++; if (c !== CW'(1)) begin n_fail++; $display("FAIL cleared_count: got %0d want 1", c); end
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL cleared_latency: got %0d want 2", cyc); end
  endtask

  task automatic test_truncate_zero();
    logic [31:0] d; logic [CW-1:0] c; int cyc;
    do_sum('{32'h3F800000, 32'h33800000}, d, c, cyc);
    n_chk++; if (d !== 32'h3F800000) begin n_fail++; $display("FAIL trunc_data: got %h want 3F800000", d); end
    do_sum('{32'h40000000, 32'h00000000}, d, c, cyc);
    n_chk++; if (d !== 32'h40000000) begin n_fail++; $display("FAIL zero_term_data: got %h want 40000000", d); end
    n_chk++; if (c !== CW'(2)) begin n_fail++; $display("FAIL zero_term_count: got %0d want 2", c); end
    do_sum('{32'h80000000}, d, c, cyc);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL neg_zero_data: got %h want 00000000", d); end
  endtask

  task automatic test_norm();
    logic [31:0] d; logic [CW-1:0] c; int cyc;
    do_sum('{32'h3FC00000, 32'hBF800000}, d, c, cyc);
    n_chk++; if (d !== 32'h3F000000) begin n_fail++; $display("FAIL norm1_data: got %h want 3F000000", d); end
    n_chk++; if (cyc !== 4) begin n_fail++; $display("FAIL norm1_latency: got %0d want 4", cyc); end
    do_sum('{32'h3F800000, 32'hBF7FFFFF}, d, c, cyc);
    n_chk++; if (d !== 32'h34000000) begin n_fail++; $display("FAIL norm23_data: got %h want 34000000", d); end
    n_chk++; if (cyc !== 26) begin n_fail++; $display("FAIL norm23_latency: got %0d want 26", cyc); end
  endtask

  task automatic test_saturate();
    logic [31:0] d; logic [CW-1:0] c; int cyc;
    do_sum('{32'h7F7FFFFF, 32'h7F7FFFFF}, d, c, cyc);
    n_chk++; if (d !== 32'h7F7FFFFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7F7FFFFF", d); end
    do_sum('{32'hFF7FFFFF, 32'hFF7FFFFF}, d, c, cyc);
    n_chk++; if (d !== 32'hFF7FFFFF) begin n_fail++; $display("FAIL sat_neg: got %h want FF7FFFFF", d); end
  endtask

  task automatic test_count_sat();
    logic [31:0] ops[$]; logic [31:0] d; logic [CW-1:0] c; int cyc;
    for (int i = 0; i < 20; i++) ops.push_back(32'h3F800000);
    do_sum(ops, d, c, cyc);
    n_chk++; if (c !== {CW{1'b1}}) begin n_fail++; $display("FAIL count_sat: got %0d want %0d", c, (1 << CW) - 1); end
    n_chk++; if (d !== 32'h41A00000) begin n_fail++; $display("FAIL count_sat_data: got %h want 41A00000", d); end
  endtask

  task automatic test_hold();
    int n; bit bad;
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b1);
    n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'h40400000 || out_count !== CW'(2) || in_ready !== 1'b0)
        bad = 1'b1;
      @(posedge clk); #1;
    end
    n_chk++; if (bad || out_data !== 32'h40400000) begin
      n_fail++; $display("FAIL hold: valid=%b data=%h cnt=%0d in_ready=%b want 1/40400000/2/0",
                         out_valid, out_data, out_count, in_ready);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [CW-1:0] c; int cyc; bit seen;
    send_op(32'h3F800000, 1'b0);
    send_op(32'hBF7FFFFF, 1'b1);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_chk++; if (seen) begin n_fail++; $display("FAIL midrst_stale: out_valid=1 want 0"); end
    do_sum('{32'h40000000}, d, c, cyc);
    n_chk++; if (d !== 32'h40000000 || c !== CW'(1)) begin
      n_fail++; $display("FAIL midrst_next: got %h/%0d want 40000000/1", d, c);
    end
  endtask

  task automatic test_random();
    logic [31:0] ops[$]; logic [31:0] m, o, d; logic [CW-1:0] c; int cyc, len;
    for (int t = 0; t < 60; t++) begin
      ops.delete();
      m = 32'h0;
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        o = rnd_op(m);
        ops.push_back(o);
        m = ref_add(m, o);
      end
      do_sum(ops, d, c, cyc);
      n_chk++; if (d !== m) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", t, d, m); end
      n_chk++; if (c !== CW'(len)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", t, c, len); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_truncate_zero();
    test_norm();
    test_saturate();
    test_count_sat();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
